// File: rtl/job_seq.sv
// job_seq: one-shot job sequencer for the matrix/stream datapath.
// A start pulse latches a job descriptor. The block then runs a timed
// matrix-write phase, a one-cycle gap, and N streaming batches. last is
// asserted on the final batch, and a watchdog aborts a stalled RUN phase.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESETN    clock, synchronous active-low reset
//   start, abort               job launch pulse / forced return to idle
//   cfg_num/i/j/rand/batches   job descriptor, latched on an accepted start
//   batch_done                 one pulse per completed output batch
//   matw, run, last            datapath controls
//   addr_num/i/j, random_num   latched descriptor fields
//   busy, done, err            job status (err is sticky until the next start)
//   batch_cnt                  completed batches of the current job
module job_seq #(
  parameter logic [23:0]    TIMEOUT = 24'hFFFFFF,
  localparam int unsigned NUM_W   = 19,
  localparam int unsigned ADDR_W  = 20,
  localparam int unsigned RAND_W  = 16,
  localparam int unsigned BATCH_W = 16,
  localparam int unsigned WD_W    = 24
) (
  input  logic               AXIS_ACLK,
  input  logic               AXIS_ARESETN,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_W-1:0]   cfg_num,
  input  logic [ADDR_W-1:0]  cfg_i,
  input  logic [ADDR_W-1:0]  cfg_j,
  input  logic [RAND_W-1:0]  cfg_rand,
  input  logic [BATCH_W-1:0] cfg_batches,
  input  logic               batch_done,
  output logic               matw,
  output logic               run,
  output logic               last,
  output logic [NUM_W-1:0]   addr_num,
  output logic [ADDR_W-1:0]  addr_i,
  output logic [ADDR_W-1:0]  addr_j,
  output logic [RAND_W-1:0]  random_num,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BATCH_W-1:0] batch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MATW = 3'd1,
    S_GAP  = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic                 matw_q, matw_d;
  logic                 run_q, run_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [NUM_W-1:0]     num_q, num_d;
  logic [ADDR_W-1:0]    i_q, i_d;
  logic [ADDR_W-1:0]    j_q, j_d;
  logic [RAND_W-1:0]    rand_q, rand_d;
  logic [BATCH_W-1:0]   total_q, total_d;
  logic [BATCH_W-1:0]   cnt_q, cnt_d;
  logic [RAND_W-1:0]    mat_cnt_q, mat_cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [BATCH_W-1:0]   cnt_inc;

  // State and output registers
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q   <= S_IDLE;
      matw_q    <= 1'b0;
      run_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      num_q     <= '0;
      i_q       <= '0;
      j_q       <= '0;
      rand_q    <= '0;
      total_q   <= '0;
      cnt_q     <= '0;
      mat_cnt_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      matw_q    <= matw_d;
      run_q     <= run_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      num_q     <= num_d;
      i_q       <= i_d;
      j_q       <= j_d;
      rand_q    <= rand_d;
      total_q   <= total_d;
      cnt_q     <= cnt_d;
      mat_cnt_q <= mat_cnt_d;
      wd_q      <= wd_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    matw_d    = matw_q;
    run_d     = run_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    num_d     = num_q;
    i_d       = i_q;
    j_d       = j_q;
    rand_d    = rand_q;
    total_d   = total_q;
    cnt_d     = cnt_q;
    mat_cnt_d = mat_cnt_q;
    wd_d      = wd_q;
    // Saturating batch count after a batch_done
    cnt_inc   = (cnt_q == {BATCH_W{1'b1}}) ? cnt_q : cnt_q + BATCH_W'(1);

    if (abort) begin
      state_d = S_IDLE;
      matw_d  = 1'b0;
      run_d   = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_d   = S_MATW;
            matw_d    = 1'b1;
            run_d     = 1'b0;
            last_d    = 1'b0;
            busy_d    = 1'b1;
            err_d     = 1'b0;
            num_d     = cfg_num;
            i_d       = cfg_i;
            j_d       = cfg_j;
            rand_d    = cfg_rand;
            total_d   = (cfg_batches == '0) ? BATCH_W'(1) : cfg_batches;
            cnt_d     = '0;
            mat_cnt_d = '0;
          end
        end
        S_MATW: begin
          if (mat_cnt_q == rand_q) begin
            state_d = S_GAP;
            matw_d  = 1'b0;
          end else begin
            mat_cnt_d = mat_cnt_q + RAND_W'(1);
          end
        end
        S_GAP: begin
          state_d = S_RUN;
          run_d   = 1'b1;
          last_d  = (total_q == BATCH_W'(1));
          wd_d    = '0;
        end
        S_RUN: begin
          if (batch_done) begin
            cnt_d = cnt_inc;
            wd_d  = '0;
            if (cnt_inc == total_q) begin
              state_d = S_DONE;
              run_d   = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (cnt_inc == total_q - BATCH_W'(1)) begin
              last_d = 1'b1;
            end
          end else if (wd_q == TIMEOUT) begin
            state_d = S_ERR;
            run_d   = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          matw_d  = 1'b0;
          run_d   = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign matw       = matw_q;
  assign run        = run_q;
  assign last       = last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign addr_num   = num_q;
  assign addr_i     = i_q;
  assign addr_j     = j_q;
  assign random_num = rand_q;
  assign batch_cnt  = cnt_q;

endmodule

// File: tb/tb_job_seq.sv
// Testbench for job_seq: a directed vector table, hand-written corner-case
// sequences, then randomized traffic checked against a timeline model.
module tb_job_seq;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, abort, batch_done;
  logic [18:0] cfg_num;
  logic [19:0] cfg_i, cfg_j;
  logic [15:0] cfg_rand, cfg_batches;
  logic        matw, run, last, busy, done, err;
  logic [18:0] addr_num;
  logic [19:0] addr_i, addr_j;
  logic [15:0] random_num, batch_cnt;

  job_seq #(.TIMEOUT(24'(TMO))) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rstn), .start(start), .abort(abort),
    .cfg_num(cfg_num), .cfg_i(cfg_i), .cfg_j(cfg_j), .cfg_rand(cfg_rand),
    .cfg_batches(cfg_batches), .batch_done(batch_done),
    .matw(matw), .run(run), .last(last), .addr_num(addr_num), .addr_i(addr_i),
    .addr_j(addr_j), .random_num(random_num), .busy(busy), .done(done),
    .err(err), .batch_cnt(batch_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Directed vector: inputs {rstn,start,abort,batch_done}, expected
  // {matw,run,last,busy,done,err} and batch_cnt after the next clock edge.
  typedef struct {
    logic [3:0]  in;
    logic [5:0]  ex;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic [3:0] in, input logic [5:0] ex, input int cnt);
    vec_t v;
    v.in  = in;
    v.ex  = ex;
    v.cnt = 16'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_matw, input logic e_run,
                         input logic e_last, input logic e_busy, input logic e_done,
                         input logic e_err, input int e_cnt);
    chk({tag, ".matw"}, 32'(matw), 32'(e_matw));
    chk({tag, ".run"},  32'(run),  32'(e_run));
    chk({tag, ".last"}, 32'(last), 32'(e_last));
    chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".err"},  32'(err),  32'(e_err));
    chk({tag, ".batch_cnt"}, 32'(batch_cnt), 32'(e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic s, input logic a, input logic b);
    start      = s;
    abort      = a;
    batch_done = b;
  endtask

  task automatic set_cfg(input int num, input int ci, input int cj, input int rnd, input int nb);
    cfg_num     = 19'(num);
    cfg_i       = 20'(ci);
    cfg_j       = 20'(cj);
    cfg_rand    = 16'(rnd);
    cfg_batches = 16'(nb);
  endtask

  // Timeline reference model: a job accepted at cycle js owns matw during
  // js+1..js+1+rand, runs from js+3+rand, and ends on the total-th batch,
  // on abort, or when TMO+1 cycles pass since RUN entry / last batch.
  bit          m_active, m_done, m_err;
  int          m_js, m_rnd, m_tot, m_cnt, m_ref;
  logic [18:0] m_num;
  logic [19:0] m_i, m_j;

  task automatic model_step();
    m_done = 0;
    if (!rstn) begin
      m_active = 0; m_err = 0; m_cnt = 0; m_rnd = 0; m_num = '0; m_i = '0; m_j = '0;
    end else if (abort) begin
      m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_js     = cyc;
        m_rnd    = int'(cfg_rand);
        m_tot    = (cfg_batches == 16'd0) ? 1 : int'(cfg_batches);
        m_num    = cfg_num;
        m_i      = cfg_i;
        m_j      = cfg_j;
        m_cnt    = 0;
        m_err    = 0;
        m_ref    = cyc + 3 + m_rnd;
      end
    end else if (cyc >= m_js + 3 + m_rnd) begin
      if (batch_done) begin
        m_cnt++;
        m_ref = cyc + 1;
        if (m_cnt == m_tot) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (cyc == m_ref + TMO) begin
        m_active = 0;
        m_err    = 1;
      end
    end
  endtask

  task automatic model_check();
    logic e_matw, e_run, e_last;
    e_matw = m_active && (cyc >= m_js + 1) && (cyc <= m_js + 1 + m_rnd);
    e_run  = m_active && (cyc >= m_js + 3 + m_rnd);
    e_last = e_run && (m_tot - m_cnt == 1);
    chk_ctl("rnd", e_matw, e_run, e_last, m_active, m_done, m_err, m_cnt);
    chk("rnd.addr_num", 32'(addr_num), 32'(m_num));
    chk("rnd.addr_i", 32'(addr_i), 32'(m_i));
    chk("rnd.addr_j", 32'(addr_j), 32'(m_j));
    chk("rnd.random_num", 32'(random_num), 32'(m_rnd));
  endtask

  initial begin
    bit quiet;
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    set_cfg(5, 7, 9, 1, 2);

    // Short job: rand=1 (2 matw cycles), 2 batches, with ignored events.
    tbl[0]  = mk(4'b0000, 6'b000000, 0);  // reset
    tbl[1]  = mk(4'b1000, 6'b000000, 0);  // idle
    tbl[2]  = mk(4'b1100, 6'b100100, 0);  // start accepted
    tbl[3]  = mk(4'b1000, 6'b100100, 0);  // second matw cycle
    tbl[4]  = mk(4'b1001, 6'b000100, 0);  // gap; batch_done in MATW ignored
    tbl[5]  = mk(4'b1001, 6'b010100, 0);  // run; batch_done in GAP ignored
    tbl[6]  = mk(4'b1001, 6'b011100, 1);  // one batch left -> last
    tbl[7]  = mk(4'b1100, 6'b011100, 1);  // start while busy ignored
    tbl[8]  = mk(4'b1001, 6'b000010, 2);  // final batch -> done
    tbl[9]  = mk(4'b1000, 6'b000000, 2);  // done is one cycle
    tbl[10] = mk(4'b1001, 6'b000000, 2);  // batch_done in DONE ignored
    tbl[11] = mk(4'b1100, 6'b100100, 0);  // restart from DONE
    tbl[12] = mk(4'b1110, 6'b000000, 0);  // abort beats start
    tbl[13] = mk(4'b1000, 6'b000000, 0);  // idle

    for (int k = 0; k < 14; k++) begin
      rstn = tbl[k].in[3];
      drive(tbl[k].in[2], tbl[k].in[1], tbl[k].in[0]);
      step();
      chk_ctl($sformatf("tbl%0d", k), tbl[k].ex[5], tbl[k].ex[4], tbl[k].ex[3],
              tbl[k].ex[2], tbl[k].ex[1], tbl[k].ex[0], int'(tbl[k].cnt));
    end
    chk("tbl.addr_num", 32'(addr_num), 32'd5);
    chk("tbl.addr_j", 32'(addr_j), 32'd9);
    drive(1'b0, 1'b0, 1'b0);

    // Reset in the middle of MATW clears everything, addresses included.
    set_cfg(11, 'h12345, 'hABCDE, 99, 1);
    drive(1'b1, 1'b0, 1'b0); step();
    chk("rstmid.addr_i", 32'(addr_i), 32'h12345);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    rstn = 1'b0; step(); rstn = 1'b1;
    chk_ctl("rstmid", 0, 0, 0, 0, 0, 0, 0);
    chk("rstmid.addr_num", 32'(addr_num), 32'd0);
    chk("rstmid.addr_i", 32'(addr_i), 32'd0);
    chk("rstmid.addr_j", 32'(addr_j), 32'd0);
    chk("rstmid.random_num", 32'(random_num), 32'd0);
    step();
    chk("rstmid.matw_after", 32'(matw), 32'd0);

    // rand=99, one batch, batch_done at T+150.
    drive(1'b1, 1'b0, 1'b0); step();              // T+1
    drive(1'b0, 1'b0, 1'b0);
    chk_ctl("long.t1", 1, 0, 0, 1, 0, 0, 0);
    chk("long.random_num", 32'(random_num), 32'd99);
    chk("long.addr_num", 32'(addr_num), 32'd11);
    repeat (99) step();                           // T+100
    chk("long.matw_t100", 32'(matw), 32'd1);
    step();                                       // T+101
    chk_ctl("long.gap", 0, 0, 0, 1, 0, 0, 0);
    step();                                       // T+102
    chk_ctl("long.run", 0, 1, 1, 1, 0, 0, 0);
    repeat (48) step();                           // T+150
    chk_ctl("long.t150", 0, 1, 1, 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1); step();              // T+151
    drive(1'b0, 1'b0, 1'b0);
    chk_ctl("long.done", 0, 0, 0, 0, 1, 0, 1);
    step();
    chk_ctl("long.after", 0, 0, 0, 0, 0, 0, 1);

    // Three batches: last only after the second batch_done.
    set_cfg(3, 1, 2, 2, 3);
    drive(1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0);
    repeat (4) step();
    chk_ctl("b3.run", 0, 1, 0, 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1); step(); drive(1'b0, 1'b0, 1'b0);
    chk_ctl("b3.bd1", 0, 1, 0, 1, 0, 0, 1);
    step();
    drive(1'b0, 1'b0, 1'b1); step(); drive(1'b0, 1'b0, 1'b0);
    chk_ctl("b3.bd2", 0, 1, 1, 1, 0, 0, 2);
    repeat (2) step();
    drive(1'b0, 1'b0, 1'b1); step(); drive(1'b0, 1'b0, 1'b0);
    chk_ctl("b3.bd3", 0, 0, 0, 0, 1, 0, 3);

    // Zero batches behaves as one; batch_done during MATW ignored.
    set_cfg(4, 4, 4, 3, 0);
    drive(1'b1, 1'b0, 1'b0); step();              // T+1
    drive(1'b0, 1'b0, 1'b1);
    repeat (2) step();                            // T+3
    drive(1'b0, 1'b0, 1'b0);
    chk_ctl("b0.matw", 1, 0, 0, 1, 0, 0, 0);
    repeat (3) step();                            // T+6
    chk_ctl("b0.run", 0, 1, 1, 1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1); step(); drive(1'b0, 1'b0, 1'b0);
    chk_ctl("b0.done", 0, 0, 0, 0, 1, 0, 1);

    // Watchdog: no batch_done for TMO+1 cycles after RUN entry.
    set_cfg(8, 8, 8, 0, 2);
    drive(1'b1, 1'b0, 1'b0); step();              // T+1
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) step();                            // RUN entry
    chk_ctl("wd.entry", 0, 1, 0, 1, 0, 0, 0);
    repeat (TMO) step();
    chk_ctl("wd.edge", 0, 1, 0, 1, 0, 0, 0);
    step();
    chk_ctl("wd.fire", 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("wd.sticky", 32'(err), 32'd1);
    drive(1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0);
    chk_ctl("wd.restart", 1, 0, 0, 1, 0, 0, 0);

    // Abort with start in RUN; start next cycle takes the new descriptor.
    repeat (2) step();
    chk("ab.run", 32'(run), 32'd1);
    set_cfg(77, 'h55, 'h66, 4, 2);
    drive(1'b1, 1'b1, 1'b0); step();
    chk_ctl("ab.abort", 0, 0, 0, 0, 0, 0, 0);
    chk("ab.hold_num", 32'(addr_num), 32'd8);
    drive(1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0);
    chk_ctl("ab.start", 1, 0, 0, 1, 0, 0, 0);
    chk("ab.addr_num", 32'(addr_num), 32'd77);
    chk("ab.addr_i", 32'(addr_i), 32'h55);
    chk("ab.random_num", 32'(random_num), 32'd4);

    // Randomized traffic against the model, starting from a reset.
    rstn = 1'b0;
    model_step();
    step();
    model_check();
    quiet = 0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 149) == 0) quiet = !quiet;
      rstn       = ($urandom_range(0, 399) != 0);
      abort      = ($urandom_range(0, 59) == 0);
      start      = ($urandom_range(0, 7) == 0);
      batch_done = !quiet && ($urandom_range(0, 3) == 0);
      set_cfg(int'($urandom_range(0, 32'h7FFFF)), int'($urandom_range(0, 32'hFFFFF)),
              int'($urandom_range(0, 32'hFFFFF)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 4)));
      model_step();
      step();
      model_check();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/job_seq.md
# job_seq

Sequencing controller for the single-core matrix/stream datapath on the AXI-Stream clock domain. It replaces the hand-driven matw/run/last bits and the constant address/length registers with one job launch. One start pulse latches a job descriptor, then runs a timed matrix-write phase followed by N streaming batches, asserting last on the final batch. A watchdog aborts a stalled job.

## Interface
- TIMEOUT, 24'hFFFFFF, max cycles in RUN without a batch_done before error (24-bit counter)
- AXIS_ACLK  in  1  clock
- AXIS_ARESETN  in  1  synchronous active-low reset
- start  in  1  job launch pulse, sampled in IDLE/DONE/ERR only
- abort  in  1  forces IDLE next cycle, highest priority after reset
- cfg_num  in  19  source words per batch minus 1
- cfg_i  in  20  exec address bound i
- cfg_j  in  20  exec address bound j
- cfg_rand  in  16  matrix-write cycles minus 1
- cfg_batches  in  16  batch count (0 treated as 1)
- batch_done  in  1  one pulse per completed output batch (TLAST & TVALID & TREADY)
- matw  out  1  matrix-write enable
- run  out  1  datapath run
- last  out  1  final-batch flag
- addr_num  out  19  latched cfg_num
- addr_i  out  20  latched cfg_i
- addr_j  out  20  latched cfg_j
- random_num  out  16  latched cfg_rand
- busy  out  1  high in MATW/GAP/RUN
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky watchdog flag, cleared by next accepted start
- batch_cnt  out  16  completed batches of current job

## Operation
- Reset: state IDLE; every output, including the address outputs, is 0.
- States: IDLE, MATW, GAP, RUN, DONE, ERR. All outputs are registered.
- IDLE/DONE/ERR + start:
  - latch cfg_* into the address outputs and an internal batch total; cfg_batches=0 becomes 1
  - clear batch_cnt, mat_cnt, err
  - go to MATW with matw=1
- MATW: mat_cnt increments each cycle. When mat_cnt==random_num: matw<=0, go to GAP. matw is high exactly random_num+1 cycles.
- GAP: one cycle with matw=run=0, then RUN with run=1. last=1 if total==1.
- RUN:
  - on batch_done: batch_cnt+1, watchdog cleared.
  - if the new count == total-1: last<=1.
  - if the new count == total: run<=0, last<=0, done<=1, go to DONE.
  - batch_done outside RUN is ignored.
- DONE: done lasts 1 cycle. The block stays in DONE (busy=0) until start. batch_cnt holds.
- Watchdog: counts RUN cycles since RUN entry or the last batch_done. On reaching TIMEOUT: run<=0, last<=0, err<=1, go to ERR.
- abort (any state): next cycle matw=run=last=busy=done=0, state IDLE. err, batch_cnt and address outputs hold.
- start together with abort: abort wins.
- start while busy: ignored, latched config unchanged.
- batch_cnt saturates at 16'hFFFF. Comparisons are at full width.

## Timing
- start at cycle T → matw=1 at T+1 through T+1+cfg_rand; busy=1 from T+1.
- GAP cycle at T+2+cfg_rand.
- run=1 from T+3+cfg_rand.
- batch_done at cycle B:
  - batch_cnt updates at B+1.
  - last rises at B+1 when that batch_done leaves exactly one batch remaining.
  - on the final batch_done, run/last fall and done pulses at B+1; busy=0 at B+1.
- Watchdog fires when the counter equals TIMEOUT: err=1 exactly TIMEOUT+1 cycles after RUN entry with no batch_done.
- A restart from DONE: the start cycle immediately follows the done pulse, with no dead cycle required.

## Test plan
- Reset mid-MATW (ARESETN low 1 cycle) → next cycle all outputs 0, state IDLE.
- cfg_rand=99, cfg_batches=1, cfg_num=11, start at T:
  - matw high T+1..T+100, run=last=1 from T+102.
  - batch_done at T+150 → done at T+151, run=0.
- cfg_batches=3:
  - last=0 after the 1st batch_done, last=1 one cycle after the 2nd batch_done.
  - done after the 3rd batch_done; batch_cnt=3.
- cfg_batches=0 → behaves as 1 (last high with run). batch_done during MATW is ignored, batch_cnt stays 0.
- TIMEOUT=50 (parameter override), no batch_done → err=1, run=0 at 51 cycles after RUN entry. A new start clears err.
- abort during RUN with start in the same cycle → IDLE, run=0. start 1 cycle later is accepted with the new config latched.
